// File: rtl/pipeline_pkg.sv
// ---------------------------------------------------------------------------
// pipeline_pkg
// Shared constants and helpers for the elastic pipeline register.
//   DEF_WIDTH  : default data width of a pipeline stage
//   DEF_DEPTH  : default number of stages
//   cnt_width(): number of bits needed to hold an occupancy of 0..depth
// ---------------------------------------------------------------------------
package pipeline_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 2;

    // Occupancy counter width: must represent every value from 0 to depth.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pipeline_stage.sv
// ---------------------------------------------------------------------------
// pipeline_stage
// One slot of the elastic pipeline: a data register plus its valid bit.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   clear                 : synchronous flush (empties slot, data -> RESET_VAL)
//   up_valid/up_ready/up_data : handshake toward the producer side
//   dn_valid/dn_ready/dn_data : handshake toward the consumer side
// dn_valid and dn_data come straight from the slot registers.
// ---------------------------------------------------------------------------
module pipeline_stage
    import pipeline_pkg::*;
#(
    parameter int               WIDTH     = DEF_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             up_valid,
    output logic             up_ready,
    input  logic [WIDTH-1:0] up_data,
    output logic             dn_valid,
    input  logic             dn_ready,
    output logic [WIDTH-1:0] dn_data
);

    logic             vld_q;
    logic             vld_d;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    // The slot can take a word when empty, or when its word leaves this cycle.
    assign up_ready = !clear && (!vld_q || dn_ready);
    assign dn_valid = vld_q;
    assign dn_data  = data_q;

    // Next-state for the slot: flush beats load, load beats drain.
    always_comb begin
        vld_d  = vld_q;
        data_d = data_q;
        if (clear) begin
            vld_d  = 1'b0;
            data_d = RESET_VAL;
        end else if (up_valid && up_ready) begin
            // Covers both filling an empty slot and refilling a draining one.
            vld_d  = 1'b1;
            data_d = up_data;
        end else if (vld_q && dn_ready) begin
            // Word leaves with nothing behind it; data is left as-is.
            vld_d  = 1'b0;
        end else begin
            vld_d  = vld_q;
        end
    end

    // Slot registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= 1'b0;
            data_q <= RESET_VAL;
        end else begin
            vld_q  <= vld_d;
            data_q <= data_d;
        end
    end

endmodule

// File: rtl/pipeline_reg.sv
// ---------------------------------------------------------------------------
// pipeline_reg
// Elastic pipeline register: DEPTH slots of WIDTH bits with valid/ready at
// both ends, bubble collapsing, synchronous flush and occupancy reporting.
// Ports:
//   clk        : clock, rising edge
//   reset      : asynchronous active-low reset
//   clear      : synchronous flush, active-high, overrides all transfers
//   in_valid/in_ready/in_data    : producer handshake
//   out_valid/out_ready/out_data : consumer handshake (out_data = last slot)
//   count      : registered number of occupied slots (0..DEPTH)
// ---------------------------------------------------------------------------
module pipeline_reg
    import pipeline_pkg::*;
#(
    parameter int               WIDTH     = DEF_WIDTH,
    parameter int               DEPTH     = DEF_DEPTH,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          clear,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [WIDTH-1:0]              in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [WIDTH-1:0]              out_data,
    output logic [cnt_width(DEPTH)-1:0]   count
);

    localparam int            CW      = cnt_width(DEPTH);
    localparam logic [CW-1:0] CNT_ONE = CW'(1'b1);

    // Per-slot interconnect, index 0 = input side, DEPTH-1 = output side.
    logic             vld_s     [DEPTH];
    logic [WIDTH-1:0] data_s    [DEPTH];
    logic             up_vld_s  [DEPTH];
    logic [WIDTH-1:0] up_dat_s  [DEPTH];
    logic             stg_rdy_s [DEPTH];
    logic             dn_rdy_s  [DEPTH];

    logic             in_xfer_s;
    logic             out_xfer_s;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;

    // Downstream-ready for every slot, derived only from the valid registers,
    // out_ready and clear. A slot is blocked exactly when it and every slot
    // after it are full and the consumer is stalled. Building the chain here
    // from register outputs keeps the instances free of a combinational
    // dependency through a shared net.
    always_comb begin : ready_chain
        logic chain_s;
        chain_s = out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            dn_rdy_s[i] = chain_s;
            chain_s     = !clear && (!vld_s[i] || chain_s);
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        if (i == 0) begin : g_head
            assign up_vld_s[i] = in_valid;
            assign up_dat_s[i] = in_data;
        end else begin : g_body
            assign up_vld_s[i] = vld_s[i-1];
            assign up_dat_s[i] = data_s[i-1];
        end

        pipeline_stage #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_stage (
            .clk      (clk),
            .rst_n    (reset),
            .clear    (clear),
            .up_valid (up_vld_s[i]),
            .up_ready (stg_rdy_s[i]),
            .up_data  (up_dat_s[i]),
            .dn_valid (vld_s[i]),
            .dn_ready (dn_rdy_s[i]),
            .dn_data  (data_s[i])
        );
    end

    // Output is masked during a flush so no word is consumed that cycle.
    assign in_ready  = stg_rdy_s[0];
    assign out_valid = vld_s[DEPTH-1] && !clear;
    assign out_data  = data_s[DEPTH-1];

    assign in_xfer_s  = in_valid && in_ready;
    assign out_xfer_s = out_valid && out_ready;

    // Occupancy next-state: flush wins, simultaneous in/out leaves it unchanged.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = {CW{1'b0}};
        end else begin
            case ({in_xfer_s, out_xfer_s})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // Occupancy register with asynchronous reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= {CW{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: tb/tb_pipeline_reg.sv
// ---------------------------------------------------------------------------
// tb_pipeline_reg
// Two instances: WIDTH=8/DEPTH=2 for directed cases, WIDTH=16/DEPTH=4 for a
// random 1000-word stream. The reference model treats each pipe as a FIFO of
// words tagged with their accept edge: the oldest word reaches the output
// DEPTH-1 edges after acceptance, the input is blocked only when the FIFO
// holds DEPTH words and the consumer is stalled, and count equals the FIFO
// size.
// ---------------------------------------------------------------------------
module tb_pipeline_reg;

    typedef struct {
        logic [15:0] data;
        int          t;
    } word_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear;

    logic        in_valid2, in_ready2, out_valid2, out_ready2;
    logic [7:0]  in_data2, out_data2;
    logic [1:0]  count2;

    logic        in_valid4, in_ready4, out_valid4, out_ready4;
    logic [15:0] in_data4, out_data4;
    logic [2:0]  count4;

    int          vectors     = 0;
    int          miscompares = 0;
    int          cyc         = 0;
    int          pops4       = 0;
    int          acc4        = 0;
    word_t       q [2][$];
    logic [7:0]  log2 [$];

    pipeline_reg #(.WIDTH(8), .DEPTH(2), .RESET_VAL(8'h00)) u_dut2 (
        .clk       (clk),
        .reset     (rst_n),
        .clear     (clear),
        .in_valid  (in_valid2),
        .in_ready  (in_ready2),
        .in_data   (in_data2),
        .out_valid (out_valid2),
        .out_ready (out_ready2),
        .out_data  (out_data2),
        .count     (count2)
    );

    pipeline_reg #(.WIDTH(16), .DEPTH(4), .RESET_VAL(16'h0000)) u_dut4 (
        .clk       (clk),
        .reset     (rst_n),
        .clear     (clear),
        .in_valid  (in_valid4),
        .in_ready  (in_ready4),
        .in_data   (in_data4),
        .out_valid (out_valid4),
        .out_ready (out_ready4),
        .out_data  (out_data4),
        .count     (count4)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Compare one DUT against the FIFO model, then advance the model by the
    // handshakes that will complete on the coming rising edge.
    task automatic model_step(input int id, input int depth, input string tag,
                              input logic rst_l, input logic clr,
                              input logic iv, input logic [15:0] idat, input logic ordy,
                              input logic dut_ir, input logic dut_ov,
                              input logic [15:0] dut_od, input int dut_cnt);
        logic  exp_ir;
        logic  exp_ov;
        word_t w;
        if (!rst_l) q[id].delete();
        exp_ir = !clr && ((q[id].size() < depth) || ordy);
        exp_ov = 1'b0;
        if (!clr && q[id].size() > 0) exp_ov = ((cyc - q[id][0].t) >= depth - 1);
        check({tag, " count"}, 32'(dut_cnt), 32'(q[id].size()));
        check({tag, " count<=depth"}, 32'(dut_cnt <= depth), 32'd1);
        check({tag, " in_ready"}, 32'(dut_ir), 32'(exp_ir));
        check({tag, " out_valid"}, 32'(dut_ov), 32'(exp_ov));
        if (dut_ov && q[id].size() > 0) check({tag, " out_data"}, 32'(dut_od), 32'(q[id][0].data));
        if (rst_l && clr) begin
            q[id].delete();
        end else if (rst_l) begin
            if (dut_ov && ordy) begin
                if (q[id].size() == 0) begin
                    check({tag, " output with empty model"}, 32'(q[id].size()), 32'd1);
                end else begin
                    if (id == 0) log2.push_back(q[id][0].data[7:0]);
                    else pops4++;
                    void'(q[id].pop_front());
                end
            end
            if (iv && exp_ir) begin
                w.data = idat;
                w.t    = cyc + 1;
                q[id].push_back(w);
            end
        end
    endtask

    // Monitor: checks both DUTs every cycle, away from the rising edge.
    always @(negedge clk) begin
        model_step(0, 2, "d2", rst_n, clear, in_valid2, {8'h00, in_data2}, out_ready2,
                   in_ready2, out_valid2, {8'h00, out_data2}, int'(count2));
        model_step(1, 4, "d4", rst_n, clear, in_valid4, in_data4, out_ready4,
                   in_ready4, out_valid4, out_data4, int'(count4));
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Offer one word to the small pipe and hold it until accepted (bounded).
    task automatic send2(input logic [7:0] d);
        bit done;
        done      = 1'b0;
        in_valid2 = 1'b1;
        in_data2  = d;
        for (int k = 0; k < 50 && !done; k++) begin
            @(negedge clk);
            if (in_ready2) done = 1'b1;
            @(posedge clk);
            #1;
        end
        check("d2 send accepted", 32'(done), 32'd1);
        in_valid2 = 1'b0;
    endtask

    initial begin
        bit took;
        rst_n      = 1'b0;
        clear      = 1'b0;
        in_valid2  = 1'b0;
        in_data2   = 8'h00;
        out_ready2 = 1'b0;
        in_valid4  = 1'b0;
        in_data4   = 16'h0000;
        out_ready4 = 1'b0;

        // Reset state
        tick(2);
        check("reset out_valid", 32'(out_valid2), 32'd0);
        check("reset out_data", 32'(out_data2), 32'h00);
        check("reset count", 32'(count2), 32'd0);
        check("reset in_ready", 32'(in_ready2), 32'd1);
        rst_n = 1'b1;
        tick(1);

        // Streaming with the consumer always ready
        out_ready2 = 1'b1;
        send2(8'hA1);
        send2(8'hB2);
        send2(8'hC3);
        tick(4);
        check("stream out count", 32'(log2.size()), 32'd3);
        if (log2.size() >= 3) begin
            check("stream out[0]", 32'(log2[0]), 32'hA1);
            check("stream out[1]", 32'(log2[1]), 32'hB2);
            check("stream out[2]", 32'(log2[2]), 32'hC3);
        end

        // Backpressure: capacity is two words
        out_ready2 = 1'b0;
        send2(8'h11);
        send2(8'h22);
        in_valid2 = 1'b1;
        in_data2  = 8'h33;
        tick(3);
        @(negedge clk);
        check("full in_ready", 32'(in_ready2), 32'd0);
        check("full count", 32'(count2), 32'd2);
        check("full out_data", 32'(out_data2), 32'h11);
        check("full out_valid", 32'(out_valid2), 32'd1);
        @(posedge clk);
        #1;
        out_ready2 = 1'b1;
        send2(8'h33);
        tick(5);
        check("drain out count", 32'(log2.size()), 32'd6);
        if (log2.size() >= 6) begin
            check("drain out[3]", 32'(log2[3]), 32'h11);
            check("drain out[4]", 32'(log2[4]), 32'h22);
            check("drain out[5]", 32'(log2[5]), 32'h33);
        end

        // Bubble between two words collapses under a stalled consumer
        out_ready2 = 1'b0;
        send2(8'h01);
        tick(1);
        send2(8'h02);
        tick(2);
        @(negedge clk);
        check("bubble count", 32'(count2), 32'd2);
        check("bubble in_ready", 32'(in_ready2), 32'd0);
        check("bubble out_data", 32'(out_data2), 32'h01);

        // Flush of a full pipe with both sides requesting a transfer
        @(posedge clk);
        #1;
        clear      = 1'b1;
        in_valid2  = 1'b1;
        in_data2   = 8'h55;
        out_ready2 = 1'b1;
        @(negedge clk);
        check("clear in_ready", 32'(in_ready2), 32'd0);
        check("clear out_valid", 32'(out_valid2), 32'd0);
        @(posedge clk);
        #1;
        clear      = 1'b0;
        in_valid2  = 1'b0;
        out_ready2 = 1'b0;
        @(negedge clk);
        check("post-clear count", 32'(count2), 32'd0);
        check("post-clear out_valid", 32'(out_valid2), 32'd0);
        check("post-clear out_data", 32'(out_data2), 32'h00);
        check("post-clear no output", 32'(log2.size()), 32'd6);

        // Asynchronous reset mid-cycle discards an in-flight word
        @(posedge clk);
        #1;
        send2(8'h77);
        tick(2);
        @(negedge clk);
        check("pre-reset out_valid", 32'(out_valid2), 32'd1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async reset out_valid", 32'(out_valid2), 32'd0);
        check("async reset count", 32'(count2), 32'd0);
        check("async reset in_ready", 32'(in_ready2), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick(2);

        // Random valid/ready stream of 1000 words through the deep pipe
        in_data4 = 16'($urandom);
        for (int c = 0; c < 20000 && acc4 < 1000; c++) begin
            in_valid4 = ($urandom_range(0, 3) != 0);
            if (((c / 64) % 2) == 0) out_ready4 = ($urandom_range(0, 3) == 0);
            else                     out_ready4 = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            took = in_valid4 && in_ready4;
            if (took) acc4++;
            @(posedge clk);
            #1;
            if (took) in_data4 = 16'($urandom);
        end
        in_valid4  = 1'b0;
        out_ready4 = 1'b1;
        tick(12);
        check("d4 words accepted", 32'(acc4), 32'd1000);
        check("d4 words delivered", 32'(pops4), 32'd1000);
        check("d4 final count", 32'(count4), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
